// File: rtl/smc_job_scheduler.sv
// Round-robin job sequencer for the single SMC instance: 6 beats in, one Enable pulse, tagged result out.
// First req_valid to rsp_valid is 8 + SMC_LAT cycles; LOAD stalls on req_valid and RESP holds until rsp_ready.
module smc_job_scheduler #(
  parameter int SMC_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [3:0] req_mode,
  input  logic [5:0] req_w,
  input  logic [5:0] req_vgs,
  input  logic [5:0] req_vds,
  output logic [1:0] mode,
  output logic [2:0] W_0,
  output logic [2:0] W_1,
  output logic [2:0] W_2,
  output logic [2:0] W_3,
  output logic [2:0] W_4,
  output logic [2:0] W_5,
  output logic [2:0] V_GS_0,
  output logic [2:0] V_GS_1,
  output logic [2:0] V_GS_2,
  output logic [2:0] V_GS_3,
  output logic [2:0] V_GS_4,
  output logic [2:0] V_GS_5,
  output logic [2:0] V_DS_0,
  output logic [2:0] V_DS_1,
  output logic [2:0] V_DS_2,
  output logic [2:0] V_DS_3,
  output logic [2:0] V_DS_4,
  output logic [2:0] V_DS_5,
  output logic       Enable,
  input  logic [9:0] out_n,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [9:0] rsp_data,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, LOAD, FIRE, WAIT, RESP} state_t;

  state_t     state, state_nxt;
  logic       grant, last_grant, pick;
  logic [2:0] beat_cnt;
  logic [3:0] wait_cnt;
  logic [2:0] w_q   [6];
  logic [2:0] vgs_q [6];
  logic [2:0] vds_q [6];
  logic [1:0] lane_mode;
  logic [2:0] lane_w, lane_vgs, lane_vds;

  // Contested grant goes to whoever did not win last time; a lone requester always wins.
  assign pick = (&req_valid) ? ~last_grant : req_valid[1];

  always_comb begin
    lane_mode = grant ? req_mode[3:2] : req_mode[1:0];
    lane_w    = grant ? req_w[5:3]    : req_w[2:0];
    lane_vgs  = grant ? req_vgs[5:3]  : req_vgs[2:0];
    lane_vds  = grant ? req_vds[5:3]  : req_vds[2:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req_valid) state_nxt = LOAD;
      LOAD:    if (req_valid[grant] && beat_cnt == 3'd5) state_nxt = FIRE;
      FIRE:    state_nxt = WAIT;
      WAIT:    if (wait_cnt == 4'd1) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    if (state == LOAD) req_ready[grant] = 1'b1;
    Enable    = (state == FIRE);
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      beat_cnt   <= 3'd0;
      wait_cnt   <= 4'd0;
      mode       <= 2'd0;
      rsp_id     <= 1'b0;
      rsp_data   <= 10'd0;
      for (int i = 0; i < 6; i++) begin
        w_q[i]   <= 3'd0;
        vgs_q[i] <= 3'd0;
        vds_q[i] <= 3'd0;
      end
    end else begin
      case (state)
        IDLE: if (|req_valid) begin
          grant      <= pick;
          last_grant <= pick;
        end
        LOAD: if (req_valid[grant]) begin
          w_q[beat_cnt]   <= lane_w;
          vgs_q[beat_cnt] <= lane_vgs;
          vds_q[beat_cnt] <= lane_vds;
          if (beat_cnt == 3'd0) mode <= lane_mode;
          beat_cnt <= (beat_cnt == 3'd5) ? 3'd0 : beat_cnt + 3'd1;
        end
        FIRE: wait_cnt <= 4'(SMC_LAT);
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            rsp_data <= out_n;
            rsp_id   <= grant;
          end
        end
        default: ;
      endcase
    end
  end

  assign W_0 = w_q[0];
  assign W_1 = w_q[1];
  assign W_2 = w_q[2];
  assign W_3 = w_q[3];
  assign W_4 = w_q[4];
  assign W_5 = w_q[5];
  assign V_GS_0 = vgs_q[0];
  assign V_GS_1 = vgs_q[1];
  assign V_GS_2 = vgs_q[2];
  assign V_GS_3 = vgs_q[3];
  assign V_GS_4 = vgs_q[4];
  assign V_GS_5 = vgs_q[5];
  assign V_DS_0 = vds_q[0];
  assign V_DS_1 = vds_q[1];
  assign V_DS_2 = vds_q[2];
  assign V_DS_3 = vds_q[3];
  assign V_DS_4 = vds_q[4];
  assign V_DS_5 = vds_q[5];

endmodule

// File: tb/tb_smc_job_scheduler.sv
// Bench for smc_job_scheduler: u_a (SMC_LAT=1) carries most jobs, u_b (SMC_LAT=4) the latency case.
module tb_smc_job_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, rsp_ready;
  logic [1:0] va, vb;
  logic [1:0] md_l [2];
  logic [2:0] w_l [2], g_l [2], d_l [2];
  logic [3:0] req_mode;
  logic [5:0] req_w, req_vgs, req_vds;
  assign req_mode = {md_l[1], md_l[0]};
  assign req_w    = {w_l[1], w_l[0]};
  assign req_vgs  = {g_l[1], g_l[0]};
  assign req_vds  = {d_l[1], d_l[0]};

  logic [1:0] rdy_a, rdy_b, mode_a, mode_b;
  logic [2:0] wa [6], ga [6], da [6], wb [6], gb [6], db [6];
  logic       en_a, en_b, rv_a, rv_b, rid_a, rid_b, busy_a, busy_b;
  logic [9:0] rdat_a, rdat_b, out_n_a, out_n_b;
  logic [5:0][2:0] pwa, pga, pda, pwb, pgb, pdb;
  logic [3:0] cnt_a, cnt_b;

  smc_job_scheduler #(.SMC_LAT(1)) u_a (
    .clk(clk), .reset(reset), .req_valid(va), .req_ready(rdy_a), .req_mode(req_mode),
    .req_w(req_w), .req_vgs(req_vgs), .req_vds(req_vds), .mode(mode_a),
    .W_0(wa[0]), .W_1(wa[1]), .W_2(wa[2]), .W_3(wa[3]), .W_4(wa[4]), .W_5(wa[5]),
    .V_GS_0(ga[0]), .V_GS_1(ga[1]), .V_GS_2(ga[2]), .V_GS_3(ga[3]), .V_GS_4(ga[4]), .V_GS_5(ga[5]),
    .V_DS_0(da[0]), .V_DS_1(da[1]), .V_DS_2(da[2]), .V_DS_3(da[3]), .V_DS_4(da[4]), .V_DS_5(da[5]),
    .Enable(en_a), .out_n(out_n_a), .rsp_valid(rv_a), .rsp_ready(rsp_ready), .rsp_id(rid_a),
    .rsp_data(rdat_a), .busy(busy_a));

  smc_job_scheduler #(.SMC_LAT(4)) u_b (
    .clk(clk), .reset(reset), .req_valid(vb), .req_ready(rdy_b), .req_mode(req_mode),
    .req_w(req_w), .req_vgs(req_vgs), .req_vds(req_vds), .mode(mode_b),
    .W_0(wb[0]), .W_1(wb[1]), .W_2(wb[2]), .W_3(wb[3]), .W_4(wb[4]), .W_5(wb[5]),
    .V_GS_0(gb[0]), .V_GS_1(gb[1]), .V_GS_2(gb[2]), .V_GS_3(gb[3]), .V_GS_4(gb[4]), .V_GS_5(gb[5]),
    .V_DS_0(db[0]), .V_DS_1(db[1]), .V_DS_2(db[2]), .V_DS_3(db[3]), .V_DS_4(db[4]), .V_DS_5(db[5]),
    .Enable(en_b), .out_n(out_n_b), .rsp_valid(rv_b), .rsp_ready(rsp_ready), .rsp_id(rid_b),
    .rsp_data(rdat_b), .busy(busy_b));

  // Stand-in SMC: positional weighted sum of the operand set.
  function automatic logic [9:0] smc_fn(input logic [1:0] m, input logic [5:0][2:0] w,
                                        input logic [5:0][2:0] g, input logic [5:0][2:0] d);
    int acc;
    acc = m * 97;
    for (int i = 0; i < 6; i++) acc += w[i] * (g[i] + 1) + d[i] * (i + 1);
    return 10'(acc);
  endfunction

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      pwa[i] = wa[i]; pga[i] = ga[i]; pda[i] = da[i];
      pwb[i] = wb[i]; pgb[i] = gb[i]; pdb[i] = db[i];
    end
    // The result is only valid exactly SMC_LAT cycles after the Enable cycle.
    out_n_a = (cnt_a == 4'd1) ? smc_fn(mode_a, pwa, pga, pda) : 10'h2AA;
    out_n_b = (cnt_b == 4'd4) ? smc_fn(mode_b, pwb, pgb, pdb) : 10'h2AA;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_a <= 4'd0;
      cnt_b <= 4'd0;
    end else begin
      cnt_a <= en_a ? 4'd1 : ((cnt_a != 4'd0 && cnt_a != 4'd15) ? cnt_a + 4'd1 : cnt_a);
      cnt_b <= en_b ? 4'd1 : ((cnt_b != 4'd0 && cnt_b != 4'd15) ? cnt_b + 4'd1 : cnt_b);
    end
  end

  int en_cnt_a = 0, both_rdy = 0;
  always @(negedge clk) begin
    if (en_a) en_cnt_a++;
    if (rdy_a == 2'b11) both_rdy++;
  end

  int total = 0, passed = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic timeout(input string nm);
    total++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  typedef struct packed { logic [1:0] m; logic [2:0] w, g, d; } beat_t;

  function automatic beat_t beat_data(input int r, input int j, input int b);
    beat_t t;
    t.m = 2'((r + j) % 4);
    t.w = 3'((r * 5 + j * 3 + b + 1) % 8);
    t.g = 3'((b + 2 * r + j) % 8);
    t.d = 3'((15 - b - r) % 8);
    return t;
  endfunction

  function automatic logic [9:0] job_exp(input int r, input int j);
    logic [5:0][2:0] w, g, d;
    beat_t t;
    for (int b = 0; b < 6; b++) begin
      t = beat_data(r, j, b);
      w[b] = t.w; g[b] = t.g; d[b] = t.d;
    end
    return smc_fn(beat_data(r, j, 0).m, w, g, d);
  endfunction

  // Streams njobs jobs back to back, holding valid between them; called at a negedge.
  task automatic drive_req(input bit sel, input int r, input int njobs, input int j0, output int first_wait);
    beat_t t;
    int k;
    first_wait = 0;
    for (int j = 0; j < njobs; j++) begin
      for (int b = 0; b < 6; b++) begin
        t = beat_data(r, j0 + j, b);
        md_l[r] = t.m; w_l[r] = t.w; g_l[r] = t.g; d_l[r] = t.d;
        if (sel) vb[r] = 1'b1; else va[r] = 1'b1;
        k = 0;
        while (!(sel ? rdy_b[r] : rdy_a[r]) && k < 200) begin
          @(posedge clk); @(negedge clk); k++;
        end
        if (j == 0 && b == 0) first_wait = k;
        if (k >= 200) timeout("beat_accept");
        @(posedge clk); @(negedge clk);
      end
    end
    if (sel) vb[r] = 1'b0; else va[r] = 1'b0;
  endtask

  task automatic wait_rsp(input int exp_id, input logic [9:0] exp_d, input string tag);
    int k = 0;
    do begin @(negedge clk); k++; end while (!rv_a && k < 200);
    if (!rv_a) timeout({tag, "_rsp"});
    else begin
      check({tag, "_id"}, 32'(rid_a), 32'(exp_id));
      check({tag, "_data"}, 32'(rdat_a), 32'(exp_d));
    end
  endtask

  task automatic to_idle();
    int k = 0;
    while (busy_a && k < 100) begin @(posedge clk); @(negedge clk); k++; end
    if (busy_a) timeout("to_idle");
  endtask

  typedef struct {
    int rid; logic [1:0] mode;
    logic [5:0][2:0] w; logic [5:0][2:0] vgs; logic [5:0][2:0] vds;
    int stall_after; int stall_len; int bp_len; int noise;
    int exp_en; int exp_rsp; int exp_acc;
  } vec_t;

  // Runs one job on u_a, cycle n = 0 being the IDLE cycle that first sees req_valid.
  task automatic run_job(input vec_t v);
    int n = 0, beat = 0, stall_left = 0, bp_left, en_n = -1, rsp_n = -1, acc_n = -1;
    int en_seen = 0, bad_other = 0, bad_stable = 0, o;
    logic [9:0] held_d = '0;
    logic       held_id = 1'b0;
    o = 1 - v.rid;
    bp_left = v.bp_len;
    if (v.noise != 0) begin
      va[o] = 1'b1; md_l[o] = 2'd3; w_l[o] = 3'd7; g_l[o] = 3'd7; d_l[o] = 3'd7;
    end
    while (acc_n < 0 && n < 300) begin
      if (rdy_a[o]) bad_other++;
      if (en_a) begin
        en_seen++;
        if (en_n < 0) begin
          en_n = n;
          check("en_W", 32'(pwa), 32'(v.w));
          check("en_VGS", 32'(pga), 32'(v.vgs));
          check("en_VDS", 32'(pda), 32'(v.vds));
          check("en_mode", 32'(mode_a), 32'(v.mode));
        end
      end
      if (stall_left > 0) begin
        va[v.rid] = 1'b0;
        check("stall_beat_cnt", 32'(u_a.beat_cnt), 32'(beat));
        stall_left--;
      end else if (beat < 6) begin
        va[v.rid] = 1'b1;
        md_l[v.rid] = (beat == 0) ? v.mode : ~v.mode;
        w_l[v.rid] = v.w[beat]; g_l[v.rid] = v.vgs[beat]; d_l[v.rid] = v.vds[beat];
        if (rdy_a[v.rid]) begin
          beat++;
          if (beat == v.stall_after + 1) stall_left = v.stall_len;
        end
      end else va[v.rid] = 1'b0;
      if (rv_a) begin
        if (rsp_n < 0) begin
          rsp_n = n; held_d = rdat_a; held_id = rid_a;
        end else if (rdat_a !== held_d || rid_a !== held_id || !busy_a) bad_stable++;
        if (bp_left > 0) begin rsp_ready = 1'b0; bp_left--; end
        else begin rsp_ready = 1'b1; acc_n = n; end
      end else rsp_ready = (v.bp_len == 0);
      if (acc_n < 0) begin @(posedge clk); @(negedge clk); n++; end
    end
    rsp_ready = 1'b1;
    if (acc_n < 0) timeout("job_accept");
    check("job_enable_cycle", 32'(en_n), 32'(v.exp_en));
    check("job_enable_count", 32'(en_seen), 32'd1);
    check("job_rsp_cycle", 32'(rsp_n), 32'(v.exp_rsp));
    check("job_accept_cycle", 32'(acc_n), 32'(v.exp_acc));
    check("job_rsp_id", 32'(held_id), 32'(v.rid));
    check("job_rsp_data", 32'(held_d), 32'(smc_fn(v.mode, v.w, v.vgs, v.vds)));
    check("job_other_ready", 32'(bad_other), 32'd0);
    check("job_rsp_stable", 32'(bad_stable), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req_ready"}, 32'(rdy_a), 32'd0);
    check({tag, "_enable"}, 32'(en_a), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rv_a), 32'd0);
    check({tag, "_rsp_id"}, 32'(rid_a), 32'd0);
    check({tag, "_rsp_data"}, 32'(rdat_a), 32'd0);
    check({tag, "_busy"}, 32'(busy_a), 32'd0);
    check({tag, "_mode"}, 32'(mode_a), 32'd0);
    check({tag, "_ops"}, 32'({pwa, pga}) | 32'(pda), 32'd0);
  endtask

  vec_t tbl [3];
  int k0, k1, en_base, cnt;

  initial begin
    tbl[0] = '{0, 2'd0, {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1}, {6{3'd3}}, {6{3'd2}}, -1, 0, 0, 0, 7, 9, 9};
    tbl[1] = '{1, 2'd2, {3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}, {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1},
               {3'd1, 3'd0, 3'd7, 3'd5, 3'd3, 3'd4}, 2, 4, 0, 0, 11, 13, 13};
    tbl[2] = '{0, 2'd1, {3'd7, 3'd1, 3'd7, 3'd1, 3'd7, 3'd1}, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5},
               {3'd5, 3'd5, 3'd6, 3'd6, 3'd7, 3'd7}, -1, 0, 10, 1, 7, 9, 19};

    reset = 1'b0; rsp_ready = 1'b1; va = 2'b00; vb = 2'b00;
    for (int i = 0; i < 2; i++) begin md_l[i] = '0; w_l[i] = '0; g_l[i] = '0; d_l[i] = '0; end
    @(negedge clk); @(negedge clk);
    check_zero("reset");
    reset = 1'b1;
    @(posedge clk); @(negedge clk);

    // Contention: both requesters hold valid for two jobs each.
    en_base = en_cnt_a;
    fork
      drive_req(1'b0, 0, 2, 0, k0);
      drive_req(1'b0, 1, 2, 0, k1);
      begin
        wait_rsp(0, job_exp(0, 0), "cont0");
        wait_rsp(1, job_exp(1, 0), "cont1");
        wait_rsp(0, job_exp(0, 1), "cont2");
        wait_rsp(1, job_exp(1, 1), "cont3");
      end
    join
    check("cont_enable_count", 32'(en_cnt_a - en_base), 32'd4);
    check("cont_both_ready", 32'(both_rdy), 32'd0);

    for (int i = 0; i < 3; i++) begin
      to_idle();
      run_job(tbl[i]);
      if (tbl[i].noise != 0) begin
        // Requester 1 waited through RESP; it must win in the IDLE cycle right after the accept.
        @(posedge clk); @(negedge clk);
        check("bp_idle_busy", 32'(busy_a), 32'd0);
        check("bp_idle_ready", 32'(rdy_a), 32'd0);
        drive_req(1'b0, 1, 1, 5, k1);
        check("bp_grant_delay", 32'(k1), 32'd1);
        wait_rsp(1, job_exp(1, 5), "bp_next");
      end
    end

    // Reset during WAIT aborts the job.
    to_idle();
    drive_req(1'b0, 0, 1, 6, k0);
    check("rst_fire_enable", 32'(en_a), 32'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check_zero("rst_mid");
    cnt = 0;
    repeat (2) begin @(negedge clk); if (rv_a || busy_a) cnt++; end
    reset = 1'b1;
    repeat (5) begin @(negedge clk); if (rv_a || busy_a) cnt++; end
    check("rst_no_response", 32'(cnt), 32'd0);
    run_job(tbl[0]);

    // SMC_LAT = 4 on u_b: WAIT spans four cycles, capture lands on FIRE+4.
    @(posedge clk); @(negedge clk);
    drive_req(1'b1, 0, 1, 7, k0);
    check("lat_fire_enable", 32'(en_b), 32'd1);
    cnt = 0;
    while (!rv_b && cnt < 50) begin @(posedge clk); @(negedge clk); cnt++; end
    if (!rv_b) timeout("lat_rsp");
    else begin
      check("lat_wait_cycles", 32'(cnt - 1), 32'd4);
      check("lat_rsp_id", 32'(rid_b), 32'd0);
      check("lat_rsp_data", 32'(rdat_b), 32'(job_exp(0, 7)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
